// File: rtl/sc_regpoint_shift.sv
// One-hot player-position register with prioritised clear/load/shift and a registered collision flag.
// Optional macro SC_REGPOINT_WRAP_EN: shifts rotate instead of saturating at the edges.
module sc_regpoint_shift #(
  parameter int DATAWIDTH = 8,
  parameter logic [DATAWIDTH-1:0] INIT_VALUE = 8'b00010000
) (
  input  logic                 SC_STATEMACHINEPOINT_CLOCK_50,
  input  logic                 SC_STATEMACHINEPOINT_RESET_InHigh,
  input  logic                 SC_REGPOINT_clear_InLow,
  input  logic                 SC_REGPOINT_load0_InLow,
  input  logic                 SC_REGPOINT_load1_InLow,
  input  logic [1:0]           SC_REGPOINT_shiftselection_In,
  input  logic [DATAWIDTH-1:0] SC_REGPOINT_data0_InBUS,
  input  logic [DATAWIDTH-1:0] SC_REGPOINT_data1_InBUS,
  input  logic [DATAWIDTH-1:0] SC_REGPOINT_obstacle_InBUS,
  output logic [DATAWIDTH-1:0] SC_REGPOINT_data_OutBUS,
  output logic                 SC_REGPOINT_bottomsidecomparator_OutLow,
  output logic                 SC_REGPOINT_moved_Out
);

  typedef enum logic {IDLE, MOVED} state_t;

  state_t                 r_state;
  logic [DATAWIDTH-1:0]   r_data;
  logic                   r_cmp;
  logic                   r_moved;
  logic [DATAWIDTH-1:0]   w_left;
  logic [DATAWIDTH-1:0]   w_right;
  logic [DATAWIDTH-1:0]   w_next;
  logic                   w_changed;

`ifdef SC_REGPOINT_WRAP_EN
  assign w_left  = {r_data[DATAWIDTH-2:0], r_data[DATAWIDTH-1]};
  assign w_right = {r_data[0], r_data[DATAWIDTH-1:1]};
`else
  // Edge saturation: a set bit at the boundary blocks the shift, even for non-one-hot values.
  assign w_left  = r_data[DATAWIDTH-1] ? r_data : {r_data[DATAWIDTH-2:0], 1'b0};
  assign w_right = r_data[0]           ? r_data : {1'b0, r_data[DATAWIDTH-1:1]};
`endif

  always_comb begin
    w_next    = r_data;
    w_changed = 1'b0;
    if (!SC_REGPOINT_clear_InLow) begin
      w_next = INIT_VALUE;
    end else if (!SC_REGPOINT_load0_InLow) begin
      w_next = SC_REGPOINT_data0_InBUS;
    end else if (!SC_REGPOINT_load1_InLow) begin
      w_next = SC_REGPOINT_data1_InBUS;
    end else begin
      case (SC_REGPOINT_shiftselection_In)
        2'b01:   w_next = w_left;
        2'b10:   w_next = w_right;
        default: w_next = r_data;
      endcase
`ifdef SC_REGPOINT_WRAP_EN
      w_changed = (SC_REGPOINT_shiftselection_In == 2'b01 ||
                   SC_REGPOINT_shiftselection_In == 2'b10) && (|r_data);
`else
      w_changed = (w_next != r_data);
`endif
    end
  end

  // Flag uses the pre-update register against the current obstacle row.
  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      r_data <= INIT_VALUE;
      r_cmp  <= 1'b1;
    end else begin
      r_data <= w_next;
      r_cmp  <= ~|(r_data & SC_REGPOINT_obstacle_InBUS);
    end
  end

  always_ff @(posedge SC_STATEMACHINEPOINT_CLOCK_50 or posedge SC_STATEMACHINEPOINT_RESET_InHigh) begin
    if (SC_STATEMACHINEPOINT_RESET_InHigh) begin
      r_state <= IDLE;
      r_moved <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_changed) begin
            r_state <= MOVED;
            r_moved <= 1'b1;
          end else begin
            r_moved <= 1'b0;
          end
        end
        MOVED: begin
          if (w_changed) begin
            r_moved <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_moved <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
          r_moved <= 1'b0;
        end
      endcase
    end
  end

  assign SC_REGPOINT_data_OutBUS                 = r_data;
  assign SC_REGPOINT_bottomsidecomparator_OutLow = r_cmp;
  assign SC_REGPOINT_moved_Out                   = r_moved;

endmodule

// File: tb/tb_sc_regpoint_shift.sv
// Directed self-checking bench for sc_regpoint_shift; honours SC_REGPOINT_WRAP_EN if defined.
module tb_sc_regpoint_shift;

  logic       clk;
  logic       rst;
  logic       clearN;
  logic       load0N;
  logic       load1N;
  logic [1:0] sel;
  logic [7:0] data0;
  logic [7:0] data1;
  logic [7:0] obstacle;
  logic [7:0] dataOut;
  logic       cmpOut;
  logic       movedOut;

  int checks;
  int failures;

  sc_regpoint_shift dut (
    .SC_STATEMACHINEPOINT_CLOCK_50          (clk),
    .SC_STATEMACHINEPOINT_RESET_InHigh      (rst),
    .SC_REGPOINT_clear_InLow                (clearN),
    .SC_REGPOINT_load0_InLow                (load0N),
    .SC_REGPOINT_load1_InLow                (load1N),
    .SC_REGPOINT_shiftselection_In          (sel),
    .SC_REGPOINT_data0_InBUS                (data0),
    .SC_REGPOINT_data1_InBUS                (data1),
    .SC_REGPOINT_obstacle_InBUS             (obstacle),
    .SC_REGPOINT_data_OutBUS                (dataOut),
    .SC_REGPOINT_bottomsidecomparator_OutLow(cmpOut),
    .SC_REGPOINT_moved_Out                  (movedOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; clearN = 1'b1; load0N = 1'b1; load1N = 1'b1;
    sel = 2'b00; data0 = 8'h00; data1 = 8'h00; obstacle = 8'h00;
    tick(); tick();
    checks++;
    if (dataOut !== 8'h10 || cmpOut !== 1'b1 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_held: data=%h cmp=%b moved=%b expected data=10 cmp=1 moved=0", dataOut, cmpOut, movedOut);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dataOut !== 8'h10 || cmpOut !== 1'b1 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release: data=%h cmp=%b moved=%b expected data=10 cmp=1 moved=0", dataOut, cmpOut, movedOut);
    end
  endtask

  task automatic test_reset_mid_shift();
    obstacle = 8'h20; sel = 2'b01;
    tick();
    tick();
    checks++;
    if (dataOut !== 8'h40 || cmpOut !== 1'b0 || movedOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL pre_reset_stream: data=%h cmp=%b moved=%b expected data=40 cmp=0 moved=1", dataOut, cmpOut, movedOut);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dataOut !== 8'h10 || cmpOut !== 1'b1 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_shift: data=%h cmp=%b moved=%b expected data=10 cmp=1 moved=0", dataOut, cmpOut, movedOut);
    end
    rst = 1'b0; sel = 2'b00; obstacle = 8'h00;
    tick();
    checks++;
    if (dataOut !== 8'h10 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL after_reset_hold: data=%h moved=%b expected data=10 moved=0", dataOut, movedOut);
    end
  endtask

  task automatic test_shift_left();
    logic [7:0] expSeq [3];
    expSeq[0] = 8'h20; expSeq[1] = 8'h40; expSeq[2] = 8'h80;
    sel = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dataOut !== expSeq[i] || movedOut !== 1'b1) begin
        failures++;
        $display("[TB] FAIL shift_left_%0d: data=%h moved=%b expected data=%h moved=1", i, dataOut, movedOut, expSeq[i]);
      end
    end
    tick();
    checks++;
`ifdef SC_REGPOINT_WRAP_EN
    if (dataOut !== 8'h01 || movedOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL shift_left_edge: data=%h moved=%b expected data=01 moved=1", dataOut, movedOut);
    end
`else
    if (dataOut !== 8'h80 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL shift_left_edge: data=%h moved=%b expected data=80 moved=0", dataOut, movedOut);
    end
`endif
    sel = 2'b00;
    tick();
    checks++;
    if (movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL hold_moved: moved=%b expected 0", movedOut);
    end
  endtask

  task automatic test_priority();
    data0 = 8'h01; data1 = 8'h80;
    clearN = 1'b0; load0N = 1'b0; load1N = 1'b0; sel = 2'b01;
    tick();
    checks++;
    if (dataOut !== 8'h10 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_clear: data=%h moved=%b expected data=10 moved=0", dataOut, movedOut);
    end
    clearN = 1'b1;
    tick();
    checks++;
    if (dataOut !== 8'h01 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_load0: data=%h moved=%b expected data=01 moved=0", dataOut, movedOut);
    end
    load0N = 1'b1;
    tick();
    checks++;
    if (dataOut !== 8'h80 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL prio_load1: data=%h moved=%b expected data=80 moved=0", dataOut, movedOut);
    end
    load1N = 1'b1; sel = 2'b00;
  endtask

  task automatic test_collision();
    data0 = 8'h08; obstacle = 8'h08; load0N = 1'b0;
    tick();
    checks++;
    if (dataOut !== 8'h08 || cmpOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coll_load: data=%h cmp=%b expected data=08 cmp=1", dataOut, cmpOut);
    end
    load0N = 1'b1;
    tick();
    checks++;
    if (cmpOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coll_hit: cmp=%b expected 0", cmpOut);
    end
    sel = 2'b10;
    tick();
    checks++;
    if (dataOut !== 8'h04 || cmpOut !== 1'b0 || movedOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL coll_shift: data=%h cmp=%b moved=%b expected data=04 cmp=0 moved=1", dataOut, cmpOut, movedOut);
    end
    sel = 2'b00;
    tick();
    checks++;
    if (cmpOut !== 1'b1 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL coll_clear: cmp=%b moved=%b expected cmp=1 moved=0", cmpOut, movedOut);
    end
    obstacle = 8'h00;
  endtask

  task automatic test_zero();
    data0 = 8'h00; load0N = 1'b0;
    tick();
    load0N = 1'b1; sel = 2'b01;
    tick();
    checks++;
    if (dataOut !== 8'h00 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_left: data=%h moved=%b expected data=00 moved=0", dataOut, movedOut);
    end
    sel = 2'b10;
    tick();
    checks++;
    if (dataOut !== 8'h00 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL zero_right: data=%h moved=%b expected data=00 moved=0", dataOut, movedOut);
    end
    sel = 2'b00;
  endtask

  task automatic test_saturate_right();
    data1 = 8'h81; load1N = 1'b0;
    tick();
    load1N = 1'b1; sel = 2'b10;
    tick();
    checks++;
`ifdef SC_REGPOINT_WRAP_EN
    if (dataOut !== 8'hC0 || movedOut !== 1'b1) begin
      failures++;
      $display("[TB] FAIL sat_right: data=%h moved=%b expected data=c0 moved=1", dataOut, movedOut);
    end
`else
    if (dataOut !== 8'h81 || movedOut !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sat_right: data=%h moved=%b expected data=81 moved=0", dataOut, movedOut);
    end
`endif
    sel = 2'b00;
    tick();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_reset_mid_shift();
    test_shift_left();
    test_priority();
    test_collision();
    test_zero();
    test_saturate_right();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
